// File: rtl/player_draw_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// player_pkg
// Shared types and constants for the player ship draw controller.
//   state_t       : sequencer states for one frame update
//   SPRITE_W/H    : ship sprite size in pixels (2 columns x 4 rows)
//   SPRITE_PIXELS : pixels plotted per ERASE or DRAW pass
//   LAST_PIXEL    : pixel counter value of the final pixel of a pass
// ---------------------------------------------------------------------------
package player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    MOVE,
    SETTLE,
    DRAW
  } state_t;

  localparam int SPRITE_W      = 2;
  localparam int SPRITE_H      = 4;
  localparam int SPRITE_PIXELS = 8;

  localparam logic [2:0] LAST_PIXEL = 3'(SPRITE_PIXELS - 1);

endpackage

// File: rtl/player_draw_ctrl_if.sv
// ---------------------------------------------------------------------------
// player_draw_if
// Bundles the button requests and the player-stage / VGA side signals of
// the draw controller.
//   btn_up, btn_down      : level move requests (synchronised to clk)
//   add_x, add_y          : sprite pixel offset for the player stage
//   y_pos_mod, y_neg_mod  : one-cycle move-up / move-down pulses
//   plot, colour          : VGA write enable and pixel colour
//   frame_done            : pulse on the last drawn pixel
// Modports: master = controller side, slave = player stage / button side.
// ---------------------------------------------------------------------------
interface player_draw_if;

  logic       btn_up;
  logic       btn_down;
  logic       add_x;
  logic [1:0] add_y;
  logic       y_pos_mod;
  logic       y_neg_mod;
  logic       plot;
  logic [2:0] colour;
  logic       frame_done;

  modport master (
    input  btn_up, btn_down,
    output add_x, add_y, y_pos_mod, y_neg_mod, plot, colour, frame_done
  );

  modport slave (
    output btn_up, btn_down,
    input  add_x, add_y, y_pos_mod, y_neg_mod, plot, colour, frame_done
  );

endinterface

// File: rtl/player_draw_ctrl_frame_divider.sv
// ---------------------------------------------------------------------------
// frame_divider
// Free-running counter 0..DIV-1 that wraps; tick is high for the one cycle
// in which the count equals DIV-1.
//   clk   : system clock
//   reset : asynchronous active-high reset (count returns to 0)
//   tick  : frame tick, one cycle every DIV clocks
// ---------------------------------------------------------------------------
module frame_divider #(
  parameter int DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] count;

  assign tick = (count == W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/player_draw_ctrl.sv
// ---------------------------------------------------------------------------
// player_draw_ctrl
// Once per frame tick, erases the 2x4 ship sprite, issues at most one
// up/down move pulse to the player stage, waits one cycle for the stage to
// update and redraws the sprite.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : player_draw_if.master (buttons in; offsets, move pulses,
//           plot/colour and frame_done out)
// Parameters: FRAME_DIV (clocks per tick, >= 19), Y_MAX (largest ship row),
//   SHIP_COLOUR (draw colour), BG_COLOUR (erase colour).
// Build option: define PLAYER_ERASE_EN to erase the old sprite before each
//   move (18-cycle sequence); without it the sequence skips ERASE (10 cycles).
// ---------------------------------------------------------------------------
module player_draw_ctrl
  import player_pkg::*;
#(
  parameter int         FRAME_DIV   = 833333,
  parameter int         Y_MAX       = 116,
  parameter logic [2:0] SHIP_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input logic          clk,
  input logic          reset,
  player_draw_if.master bus
);

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic [6:0] shadow_y;
  logic       up_req, dn_req;
  logic       tick;

  logic       add_x, plot, pos_pulse, neg_pulse, done;
  logic [1:0] add_y;
  logic [2:0] colour;

  frame_divider #(.DIV(FRAME_DIV)) u_frame_divider (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // shadow_y mirrors the player stage's row so bound checks need no feedback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      shadow_y <= '0;
      up_req   <= 1'b0;
      dn_req   <= 1'b0;
    end else begin
      if (state == ERASE || state == DRAW) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (state == IDLE && tick) begin
        up_req <= bus.btn_up & ~bus.btn_down;
        dn_req <= bus.btn_down & ~bus.btn_up;
      end
      if (pos_pulse) begin
        shadow_y <= shadow_y - 1'b1;
      end else if (neg_pulse) begin
        shadow_y <= shadow_y + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    add_x     = 1'b0;
    add_y     = 2'b00;
    plot      = 1'b0;
    colour    = BG_COLOUR;
    pos_pulse = 1'b0;
    neg_pulse = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // ticks outside IDLE are simply not looked at, so they are dropped
        if (tick) begin
`ifdef PLAYER_ERASE_EN
          state_nx = ERASE;
`else
          state_nx = MOVE;
`endif
        end
      end
      ERASE: begin
        plot  = 1'b1;
        add_x = cnt[0];
        add_y = cnt[2:1];
        if (cnt == LAST_PIXEL) begin
          state_nx = MOVE;
        end
      end
      MOVE: begin
        // up_req and dn_req are mutually exclusive, so the pulses are too
        pos_pulse = up_req && (shadow_y != 7'd0);
        neg_pulse = dn_req && (shadow_y < 7'(Y_MAX));
        state_nx  = SETTLE;
      end
      SETTLE: begin
        state_nx = DRAW;
      end
      DRAW: begin
        plot   = 1'b1;
        colour = SHIP_COLOUR;
        add_x  = cnt[0];
        add_y  = cnt[2:1];
        if (cnt == LAST_PIXEL) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.add_x      = add_x;
  assign bus.add_y      = add_y;
  assign bus.plot       = plot;
  assign bus.colour     = colour;
  assign bus.y_pos_mod  = pos_pulse;
  assign bus.y_neg_mod  = neg_pulse;
  assign bus.frame_done = done;

endmodule

// File: tb/tb_player_draw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_draw_ctrl
// Self-checking bench for player_draw_ctrl with FRAME_DIV=20. A frame-level
// model predicts the per-cycle outputs of each sequence from the tick time,
// the buttons seen at the tick and a clamped ship row.
// ---------------------------------------------------------------------------
module tb_player_draw_ctrl;

  localparam int         FRAME_DIV = 20;
  localparam int         Y_MAX     = 116;
  localparam logic [2:0] SHIP      = 3'b010;
  localparam logic [2:0] BG        = 3'b000;

`ifdef PLAYER_ERASE_EN
  localparam int FIRST_PLOT_C = 20;
  localparam int FIRST_DONE_C = 37;
`else
  localparam int FIRST_PLOT_C = 22;
  localparam int FIRST_DONE_C = 29;
`endif

  typedef struct {
    bit       plot;
    bit [2:0] colour;
    bit       add_x;
    bit [1:0] add_y;
    bit       pos;
    bit       neg;
    bit       done;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  player_draw_if pif();

  always #5 clk = ~clk;

  player_draw_ctrl #(
    .FRAME_DIV  (FRAME_DIV),
    .Y_MAX      (Y_MAX),
    .SHIP_COLOUR(SHIP),
    .BG_COLOUR  (BG)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (pif)
  );

  int total = 0;
  int bad   = 0;

  exp_t q[$];
  int shadow_m     = 0;
  int fcnt         = 0;
  int cyc          = 0;
  int first_plot_c = -1;
  int first_done_c = -1;
  int pos_cnt      = 0;
  int neg_cnt      = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)",
               name, actual, expected, cyc, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.plot   = 1'b0;
    e.colour = BG;
    e.add_x  = 1'b0;
    e.add_y  = 2'b00;
    e.pos    = 1'b0;
    e.neg    = 1'b0;
    e.done   = 1'b0;
    return e;
  endfunction

  function automatic exp_t pixel_exp(input int i, input bit [2:0] col);
    exp_t e;
    e        = idle_exp();
    e.plot   = 1'b1;
    e.colour = col;
    e.add_x  = 1'((i % 2));
    e.add_y  = 2'((i / 2));
    e.done   = (col == SHIP) && (i == 7);
    return e;
  endfunction

  // One whole frame's worth of expected outputs, queued at the tick cycle
  task automatic build_frame(input bit up, input bit dn);
    exp_t e;
    bit up_r;
    bit dn_r;
    up_r = up && !dn;
    dn_r = dn && !up;
`ifdef PLAYER_ERASE_EN
    for (int i = 0; i < 8; i++) q.push_back(pixel_exp(i, BG));
`endif
    e = idle_exp();
    if (up_r && shadow_m > 0) begin
      e.pos = 1'b1;
      shadow_m--;
    end else if (dn_r && shadow_m < Y_MAX) begin
      e.neg = 1'b1;
      shadow_m++;
    end
    q.push_back(e);
    q.push_back(idle_exp());
    for (int i = 0; i < 8; i++) q.push_back(pixel_exp(i, SHIP));
  endtask

  task automatic compare_out(input exp_t e);
    checkOutput("plot",       int'(pif.plot),       int'(e.plot));
    checkOutput("colour",     int'(pif.colour),     int'(e.colour));
    checkOutput("add_x",      int'(pif.add_x),      int'(e.add_x));
    checkOutput("add_y",      int'(pif.add_y),      int'(e.add_y));
    checkOutput("y_pos_mod",  int'(pif.y_pos_mod),  int'(e.pos));
    checkOutput("y_neg_mod",  int'(pif.y_neg_mod),  int'(e.neg));
    checkOutput("frame_done", int'(pif.frame_done), int'(e.done));
  endtask

  // Compare process: every falling edge, check outputs against the model
  initial begin
    exp_t e;
    bit busy;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        shadow_m     = 0;
        fcnt         = 0;
        cyc          = 0;
        first_plot_c = -1;
        first_done_c = -1;
        compare_out(idle_exp());
      end else begin
        busy = (q.size() != 0);
        if (busy) e = q.pop_front();
        else      e = idle_exp();
        compare_out(e);
        if (pif.plot && first_plot_c < 0) first_plot_c = cyc;
        if (pif.frame_done && first_done_c < 0) first_done_c = cyc;
        if (pif.y_pos_mod) pos_cnt++;
        if (pif.y_neg_mod) neg_cnt++;
        if (!busy && fcnt == FRAME_DIV - 1) build_frame(pif.btn_up, pif.btn_down);
        fcnt = (fcnt == FRAME_DIV - 1) ? 0 : fcnt + 1;
        cyc++;
      end
    end
  end

  task automatic applyStimulus(input bit up, input bit dn, input int n);
    pif.btn_up   = up;
    pif.btn_down = dn;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int p0;
    int n0;
    bit found;
    pif.btn_up   = 1'b0;
    pif.btn_down = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_plot",   int'(pif.plot), 0);
    checkOutput("reset_colour", int'(pif.colour), int'(BG));
    checkOutput("reset_done",   int'(pif.frame_done), 0);
    reset = 1'b0;
    $display("[TB] reset released");

    applyStimulus(1'b0, 1'b0, 60);
    checkOutput("first_plot_cycle", first_plot_c, FIRST_PLOT_C);
    checkOutput("first_done_cycle", first_done_c, FIRST_DONE_C);

    n0 = neg_cnt;
    applyStimulus(1'b0, 1'b1, 3 * FRAME_DIV);
    applyStimulus(1'b0, 1'b0, FRAME_DIV);
    checkOutput("down3_pulses", neg_cnt - n0, 3);
    checkOutput("down3_row", shadow_m, 3);

    p0 = pos_cnt;
    applyStimulus(1'b1, 1'b0, 5 * FRAME_DIV);
    applyStimulus(1'b0, 1'b0, FRAME_DIV);
    checkOutput("up5_pulses", pos_cnt - p0, 3);
    checkOutput("up5_row", shadow_m, 0);

    p0 = pos_cnt;
    applyStimulus(1'b1, 1'b0, FRAME_DIV);
    applyStimulus(1'b0, 1'b0, FRAME_DIV);
    checkOutput("up_at_top_pulses", pos_cnt - p0, 0);

    n0 = neg_cnt;
    applyStimulus(1'b0, 1'b1, 118 * FRAME_DIV);
    applyStimulus(1'b0, 1'b0, FRAME_DIV);
    checkOutput("down118_pulses", neg_cnt - n0, 116);
    checkOutput("down118_row", shadow_m, 116);

    n0 = neg_cnt;
    applyStimulus(1'b0, 1'b1, FRAME_DIV);
    applyStimulus(1'b0, 1'b0, FRAME_DIV);
    checkOutput("down_at_bottom_pulses", neg_cnt - n0, 0);

    p0 = pos_cnt;
    n0 = neg_cnt;
    applyStimulus(1'b1, 1'b1, 2 * FRAME_DIV);
    applyStimulus(1'b0, 1'b0, FRAME_DIV);
    checkOutput("both_held_pulses", (pos_cnt - p0) + (neg_cnt - n0), 0);

    // buttons only while the frame counter is far from its tick value
    p0 = pos_cnt;
    n0 = neg_cnt;
    for (int i = 0; i < 4 * FRAME_DIV; i++) begin
      if (fcnt >= 3 && fcnt <= 12)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      else
        applyStimulus(1'b0, 1'b0, 1);
    end
    applyStimulus(1'b0, 1'b0, FRAME_DIV);
    checkOutput("midframe_pulses", (pos_cnt - p0) + (neg_cnt - n0), 0);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 30)));
    end
    applyStimulus(1'b0, 1'b0, FRAME_DIV);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (pif.plot && pif.colour == SHIP && pif.add_y == 2'd2 && pif.add_x == 1'b0)
        found = 1'b1;
    end
    checkOutput("draw_cnt4_seen", int'(found), 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_plot", int'(pif.plot), 0);
    checkOutput("abort_colour", int'(pif.colour), int'(BG));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 60);
    checkOutput("restart_first_plot", first_plot_c, FIRST_PLOT_C);
    checkOutput("restart_first_done", first_done_c, FIRST_DONE_C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_draw_ctrl.md
PLAYER_DRAW_CTRL -- requirements
Module: player_draw_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL be used.
REQ-002 Parameter FRAME_DIV, default 833333, SHALL set the clocks per frame tick (50 MHz / 60 Hz); legal values SHALL be 19 or more.
REQ-003 Parameter Y_MAX, default 116, SHALL be the largest legal ship origin row (120 rows minus sprite height 4).
REQ-004 Parameter SHIP_COLOUR, default 3'b010, SHALL be the draw colour.
REQ-005 Parameter BG_COLOUR, default 3'b000, SHALL be the erase colour.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 btn_up  in  1  level request to move the ship up, already synchronised to clk.
REQ-009 btn_down  in  1  level request to move the ship down, already synchronised to clk.
REQ-010 add_x  out  1  sprite column offset, to the player stage.
REQ-011 add_y  out  2  sprite row offset, to the player stage.
REQ-012 y_pos_mod  out  1  one-cycle pulse; the player stage moves up one row.
REQ-013 y_neg_mod  out  1  one-cycle pulse; the player stage moves down one row.
REQ-014 plot  out  1  VGA write enable for the current pixel.
REQ-015 colour  out  3  VGA colour for the current pixel.
REQ-016 frame_done  out  1  one-cycle pulse on the last DRAW pixel.

Function
REQ-017 A frame counter SHALL count 0 to FRAME_DIV-1 and wrap; tick SHALL be asserted when the count equals FRAME_DIV-1.
REQ-018 States SHALL be IDLE, ERASE, MOVE, SETTLE and DRAW.
REQ-019 IDLE SHALL go to ERASE on tick; at the same edge it SHALL latch up_req=btn_up&~btn_down and dn_req=btn_down&~btn_up.
REQ-020 Both buttons pressed at tick SHALL produce no move.
REQ-021 ERASE and DRAW SHALL each last exactly 8 cycles, driven by a 3-bit pixel counter with add_x=cnt[0] and add_y=cnt[2:1].
REQ-022 ERASE and DRAW SHALL drive plot=1; colour SHALL be BG_COLOUR in ERASE and SHIP_COLOUR in DRAW.
REQ-023 After cnt=7, ERASE SHALL go to MOVE.
REQ-024 MOVE SHALL last 1 cycle with plot=0; it SHALL assert y_pos_mod if up_req and shadow_y>0, and y_neg_mod if dn_req and shadow_y<Y_MAX.
REQ-025 shadow_y (7-bit) SHALL decrement or increment in the same cycle as the pulse it issues; at the 0 and Y_MAX bounds no pulse SHALL be issued and no wrap SHALL occur.
REQ-026 y_pos_mod and y_neg_mod SHALL never be asserted together.
REQ-027 SETTLE SHALL last 1 cycle with plot=0, so the player stage register has updated before DRAW.
REQ-028 DRAW SHALL assert frame_done at cnt=7 and then return to IDLE.
REQ-029 A full frame sequence SHALL take 18 cycles.
REQ-030 A tick arriving outside IDLE SHALL be dropped, not queued.
REQ-031 Outside ERASE and DRAW, add_x and add_y SHALL be 0 and plot SHALL be 0.

Reset
REQ-032 Reset SHALL force state IDLE, frame counter 0, pixel counter 0, shadow_y 0, up_req and dn_req 0.
REQ-033 During reset, all pulse outputs and plot SHALL be 0 and colour SHALL be BG_COLOUR.
REQ-034 Reset asserted mid-sequence SHALL abort immediately; no further plot or move pulse SHALL be emitted.
REQ-035 shadow_y SHALL reset to 0, matching the player stage's y reset value.

Configuration
REQ-036 With PLAYER_ERASE_EN defined, the block SHALL behave as above.
REQ-037 Without PLAYER_ERASE_EN, IDLE SHALL go directly to MOVE on tick, no BG_COLOUR plot SHALL occur, and a full sequence SHALL take 10 cycles.

Structure
REQ-038 Package player_pkg SHALL hold the state enum and the constants SPRITE_W=2, SPRITE_H=4 and SPRITE_PIXELS=8.
REQ-039 The frame counter SHALL be a sub-module, frame_divider (parameter DIV, output tick).

Verification (FRAME_DIV=20)
REQ-040 Release reset, no buttons -> first tick at cycle 19; then 8 plots with colour 000 and (add_y,add_x)=00,01,10,...,31; then MOVE with no pulse; SETTLE; 8 plots with colour 010; frame_done on the 18th cycle.
REQ-041 Hold btn_down for 3 frames -> exactly one y_neg_mod per frame, and shadow_y=3.
REQ-042 btn_up at shadow_y=0 -> no y_pos_mod and shadow_y stays 0; drive 116 downs, then btn_down -> no y_neg_mod at 116.
REQ-043 Both buttons held -> no pulses; with btn_up and btn_down pulsed mid-frame only, outside tick -> no move.
REQ-044 Assert reset during DRAW cnt=4 -> plot=0 the same cycle; the next sequence starts at the next tick after release.
REQ-045 With PLAYER_ERASE_EN undefined -> no colour-000 plots, and frame_done occurs 10 cycles after tick.
